// File: rtl/store_commit_buffer.sv
// Store commit buffer: FIFO of retired stores drained one byte per cycle to a granted byte port.
// Optional macro STORE_BUF_HAZARD_EN enables exact address-overlap hazard; otherwise hazard = !empty.
//
// state  | meaning
// IDLE   | no store being drained; leaves when count>0
// REQ    | mem_req asserted, waiting for mem_gnt
// WRITE  | grant held, writing byte byte_idx of the head entry each cycle
module store_commit_buffer #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
   input  logic        push_valid,
   input  logic [31:0] push_addr,
   input  logic [31:0] push_data,
   input  logic [1:0]  push_size,
   output logic        push_ready,
   output logic        empty,
   input  logic [31:0] qry_addr,
   input  logic [1:0]  qry_size,
   output logic        hazard,
   output logic        mem_req,
   input  logic        mem_gnt,
   output logic        mem_wr,
   output logic [31:0] mem_a,
   output logic [7:0]  mem_dout
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE} state_t;

   localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
   localparam logic [PTR_W:0]   CNT_ONE  = 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = 1;

   logic [31:0]      addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [1:0]       size_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [PTR_W-1:0] head_q, tail_q;
   logic [PTR_W:0]   count_q, count_d;
   logic [1:0]       byte_idx_q, byte_idx_d;
   state_t           state_q, state_d;

   logic push_acc, pop, last_byte;

   function automatic logic [1:0] last_idx(input logic [1:0] s);
      case (s)
         2'd0:    return 2'd0;
         2'd1:    return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   function automatic logic [32:0] size_bytes(input logic [1:0] s);
      case (s)
         2'd0:    return 33'd1;
         2'd1:    return 33'd2;
         default: return 33'd4;
      endcase
   endfunction

   // Readiness comes from the registered count only, so a same-edge pop never frees a slot early.
   assign push_ready = (count_q != FULL_CNT);
   assign empty      = (count_q == '0) && (state_q == S_IDLE);
   assign push_acc   = rdy && push_valid && push_ready;
   assign last_byte  = (byte_idx_q == last_idx(size_q[head_q]));
   assign pop        = rdy && (state_q == S_WRITE) && last_byte;

   always_comb begin
      count_d = count_q;
      unique case ({push_acc, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      mem_req    = 1'b0;
      mem_wr     = 1'b0;
      mem_a      = 32'd0;
      mem_dout   = 8'd0;
      unique case (state_q)
         S_IDLE: begin
            if (count_q != '0) state_d = S_REQ;
         end
         S_REQ: begin
            mem_req = rdy;
            if (mem_gnt) begin
               state_d    = S_WRITE;
               byte_idx_d = 2'd0;
            end
         end
         S_WRITE: begin
            mem_req  = rdy;
            mem_wr   = rdy;
            mem_a    = addr_q[head_q] + {30'd0, byte_idx_q};
            mem_dout = data_q[head_q][{byte_idx_q, 3'b000} +: 8];
            if (last_byte) begin
               byte_idx_d = 2'd0;
               state_d    = (count_d != '0) ? S_REQ : S_IDLE;
            end else begin
               byte_idx_d = byte_idx_q + 2'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         byte_idx_q <= 2'd0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         valid_q    <= '0;
      end else if (rdy) begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         count_q    <= count_d;
         if (pop) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + PTR_ONE;
         end
         if (push_acc) begin
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + PTR_ONE;
         end
      end
   end

   // Payload storage needs no reset; valid_q and count_q gate every use of it.
   always_ff @(posedge clk) begin
      if (push_acc) begin
         addr_q[tail_q] <= push_addr;
         data_q[tail_q] <= push_data;
         size_q[tail_q] <= push_size;
      end
   end

`ifdef STORE_BUF_HAZARD_EN
   logic [32:0]      q_lo, q_hi;
   logic [DEPTH-1:0] hit;

   // 33-bit bounds keep a range that ends past 0xFFFFFFFF from matching low addresses.
   assign q_lo = {1'b0, qry_addr};
   assign q_hi = q_lo + size_bytes(qry_size);

   for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
      logic [32:0] e_lo, e_hi;
      assign e_lo   = {1'b0, addr_q[g]};
      assign e_hi   = e_lo + size_bytes(size_q[g]);
      assign hit[g] = valid_q[g] && (e_lo < q_hi) && (q_lo < e_hi);
   end

   assign hazard = |hit;
`else
   logic unused_qry;
   assign unused_qry = ^{qry_addr, qry_size, valid_q, size_bytes(2'd0)};
   assign hazard     = !empty;
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Self-checking bench for store_commit_buffer: directed scenarios plus randomized traffic
// compared against a queue-based model of pending stores and their byte streams.
module tb_store_commit_buffer;

   logic        clk = 1'b0;
   logic        rst_n, rdy, push_valid, mem_gnt;
   logic [31:0] push_addr, push_data, qry_addr;
   logic [1:0]  push_size, qry_size;
   logic        push_ready, empty, hazard, mem_req, mem_wr;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;

   int total = 0;
   int bad   = 0;
   bit mon_on = 1'b0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      int          n;
      int          idx;
   } st_t;
   st_t pend[$];

   store_commit_buffer dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy),
      .push_valid(push_valid), .push_addr(push_addr), .push_data(push_data), .push_size(push_size),
      .push_ready(push_ready), .empty(empty),
      .qry_addr(qry_addr), .qry_size(qry_size), .hazard(hazard),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wr(mem_wr), .mem_a(mem_a), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   function automatic int nb(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit exp_hazard();
`ifdef STORE_BUF_HAZARD_EN
      longint ql, qh, el, eh;
      ql = longint'(qry_addr);
      qh = ql + nb(qry_size);
      foreach (pend[i]) begin
         el = longint'(pend[i].a);
         eh = el + pend[i].n;
         if (el < qh && ql < eh) return 1'b1;
      end
      return 1'b0;
`else
      return pend.size() > 0;
`endif
   endfunction

   // Model follows the DUT between edges: checks the current cycle, then applies this edge's commits.
   st_t         mh;
   bit          mfull;
   logic [31:0] ea;
   logic [7:0]  ed;
   always @(negedge clk) begin
      if (mon_on && rst_n) begin
         mfull = (pend.size() == 8);
         total++;
         if (push_ready !== !mfull) begin
            bad++; $display("FAIL push_ready: got %b want %b", push_ready, !mfull);
         end
         total++;
         if (empty !== (pend.size() == 0)) begin
            bad++; $display("FAIL empty: got %b want %b", empty, pend.size() == 0);
         end
         total++;
         if (hazard !== exp_hazard()) begin
            bad++; $display("FAIL hazard: got %b want %b (qry %h/%0d)", hazard, exp_hazard(), qry_addr, qry_size);
         end
         if (!rdy) begin
            total++;
            if (mem_req !== 1'b0 || mem_wr !== 1'b0) begin
               bad++; $display("FAIL rdy_freeze: mem_req=%b mem_wr=%b want 0 0", mem_req, mem_wr);
            end
         end
         if (mem_wr === 1'b1) begin
            total++;
            if (pend.size() == 0) begin
               bad++; $display("FAIL stray_write: got write %h=%h want none", mem_a, mem_dout);
            end else begin
               mh = pend[0];
               ea = mh.a + 32'(mh.idx);
               ed = 8'(mh.d >> (8 * mh.idx));
               if (mem_a !== ea || mem_dout !== ed) begin
                  bad++; $display("FAIL byte_write: got %h=%h want %h=%h", mem_a, mem_dout, ea, ed);
               end
               mh.idx++;
               if (mh.idx == mh.n) void'(pend.pop_front());
               else pend[0] = mh;
            end
         end
         if (push_valid && rdy && !mfull) begin
            mh.a = push_addr; mh.d = push_data; mh.n = nb(push_size); mh.idx = 0;
            pend.push_back(mh);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      push_valid = 1'b1; push_addr = a; push_data = d; push_size = s;
      tick();
      push_valid = 1'b0;
   endtask

   task automatic wait_empty(input int limit, input string name);
      int c = 0;
      while (empty !== 1'b1 && c < limit) begin tick(); c++; end
      total++;
      if (empty !== 1'b1 || pend.size() != 0) begin
         bad++; $display("FAIL %s: empty=%b model_pending=%0d want 1 0", name, empty, pend.size());
      end
   endtask

   task automatic wait_wr(input string name);
      int c = 0;
      while (mem_wr !== 1'b1 && c < 50) begin tick(); c++; end
      total++;
      if (mem_wr !== 1'b1) begin
         bad++; $display("FAIL %s: mem_wr=%b want 1 within 50 cycles", name, mem_wr);
      end
   endtask

   task automatic check_reset_outs(input string name);
      total++;
      if (push_ready !== 1'b1 || empty !== 1'b1 || hazard !== 1'b0 || mem_req !== 1'b0 ||
          mem_wr !== 1'b0 || mem_a !== 32'd0 || mem_dout !== 8'd0) begin
         bad++;
         $display("FAIL %s: got rdy=%b emp=%b haz=%b req=%b wr=%b a=%h d=%h want 1 1 0 0 0 0 0",
                  name, push_ready, empty, hazard, mem_req, mem_wr, mem_a, mem_dout);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      check_reset_outs("reset_held");
      rst_n = 1'b1;
      tick();
      check_reset_outs("reset_released");
      mon_on = 1'b1;
   endtask

   task automatic test_single_sw();
      int cycles = 0;
      int nwr = 0;
      bit first_ok = 1'b0;
      mem_gnt = 1'b1;
      push_one(32'h100, 32'hA1B2C3D4, 2'd2);
      while (empty !== 1'b1 && cycles < 50) begin
         if (mem_wr === 1'b1) begin
            if (nwr == 0) first_ok = (mem_a === 32'h100 && mem_dout === 8'hD4);
            nwr++;
         end
         tick();
         cycles++;
      end
      total++;
      if (cycles != 6) begin bad++; $display("FAIL sw_latency: got %0d cycles want 6", cycles); end
      total++;
      if (nwr != 4) begin bad++; $display("FAIL sw_write_count: got %0d want 4", nwr); end
      total++;
      if (!first_ok) begin bad++; $display("FAIL sw_first_byte: got wrong want 00000100=d4"); end
   endtask

   task automatic test_fill();
      mem_gnt = 1'b0;
      for (int i = 0; i < 8; i++) push_one($urandom, $urandom, 2'($urandom_range(0, 3)));
      total++;
      if (push_ready !== 1'b0) begin bad++; $display("FAIL fill_full: push_ready=%b want 0", push_ready); end
      push_one(32'hDEAD_0000, 32'h1111_2222, 2'd2);
      total++;
      if (push_ready !== 1'b0) begin bad++; $display("FAIL fill_ninth: push_ready=%b want 0", push_ready); end
      mem_gnt = 1'b1;
      wait_empty(200, "fill_drain");
   endtask

   task automatic test_push_on_pop();
      mem_gnt = 1'b0;
      for (int i = 0; i < 7; i++) push_one($urandom, $urandom, 2'd0);
      mem_gnt = 1'b1;
      wait_wr("pop7_wait");
      push_valid = 1'b1; push_addr = 32'h500; push_data = 32'h5A; push_size = 2'd0;
      total++;
      if (push_ready !== 1'b1) begin bad++; $display("FAIL pop7_ready: push_ready=%b want 1", push_ready); end
      tick();
      push_valid = 1'b0;
      total++;
      if (push_ready !== 1'b1 || empty !== 1'b0) begin
         bad++; $display("FAIL pop7_after: ready=%b empty=%b want 1 0", push_ready, empty);
      end
      wait_empty(200, "pop7_drain");

      mem_gnt = 1'b0;
      for (int i = 0; i < 8; i++) push_one($urandom, $urandom, 2'd0);
      mem_gnt = 1'b1;
      wait_wr("pop8_wait");
      push_valid = 1'b1; push_addr = 32'h600; push_data = 32'hA5; push_size = 2'd0;
      total++;
      if (push_ready !== 1'b0) begin bad++; $display("FAIL pop8_refuse: push_ready=%b want 0", push_ready); end
      tick();
      push_valid = 1'b0;
      total++;
      if (push_ready !== 1'b1) begin bad++; $display("FAIL pop8_after: push_ready=%b want 1", push_ready); end
      wait_empty(200, "pop8_drain");
   endtask

   task automatic test_hazard();
      bit exp_far;
`ifdef STORE_BUF_HAZARD_EN
      exp_far = 1'b0;
`else
      exp_far = 1'b1;
`endif
      mem_gnt = 1'b0;
      push_one(32'h202, 32'h0000_BEEF, 2'd1);
      qry_addr = 32'h200; qry_size = 2'd2; #1;
      total++;
      if (hazard !== 1'b1) begin bad++; $display("FAIL haz_lw200: got %b want 1", hazard); end
      qry_addr = 32'h204; qry_size = 2'd0; #1;
      total++;
      if (hazard !== exp_far) begin bad++; $display("FAIL haz_lb204: got %b want %b", hazard, exp_far); end
      qry_addr = 32'h203; qry_size = 2'd0; #1;
      total++;
      if (hazard !== 1'b1) begin bad++; $display("FAIL haz_lb203: got %b want 1", hazard); end
      push_one(32'hFFFF_FFFF, 32'h77, 2'd0);
      qry_addr = 32'h0; qry_size = 2'd2; #1;
      total++;
      if (hazard !== exp_far) begin bad++; $display("FAIL haz_wrap: got %b want %b", hazard, exp_far); end
      mem_gnt = 1'b1;
      wait_empty(100, "haz_drain");
      qry_addr = 32'h200; qry_size = 2'd2; #1;
      total++;
      if (hazard !== 1'b0) begin bad++; $display("FAIL haz_empty: got %b want 0", hazard); end
   endtask

   task automatic test_rdy_stall();
      mem_gnt = 1'b1;
      push_one(32'h300, 32'h1234_5678, 2'd1);
      wait_wr("stall_wait");
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (mem_wr !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL stall_%0d: mem_wr=%b mem_req=%b want 0 0", i, mem_wr, mem_req);
         end
         tick();
      end
      rdy = 1'b1; #1;
      total++;
      if (mem_wr !== 1'b1 || mem_a !== 32'h300 || mem_dout !== 8'h78) begin
         bad++; $display("FAIL stall_resume: got %b %h=%h want 1 00000300=78", mem_wr, mem_a, mem_dout);
      end
      wait_empty(50, "stall_drain");
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         rdy        = ($urandom_range(0, 7) != 0);
         mem_gnt    = ($urandom_range(0, 2) != 0);
         push_valid = $urandom_range(0, 1);
         push_addr  = ($urandom_range(0, 1) != 0) ? {24'd0, 8'($urandom)} : $urandom;
         push_data  = $urandom;
         push_size  = 2'($urandom_range(0, 3));
         qry_addr   = ($urandom_range(0, 3) != 0) ? {24'd0, 8'($urandom)} : $urandom;
         qry_size   = 2'($urandom_range(0, 3));
         tick();
      end
      rdy = 1'b1; mem_gnt = 1'b1; push_valid = 1'b0;
      wait_empty(300, "random_drain");
   endtask

   task automatic test_reset_mid_drain();
      int wr_seen = 0;
      mem_gnt = 1'b1;
      push_one(32'h400, 32'hCAFE_F00D, 2'd2);
      wait_wr("rst_wait");
      tick();
      mon_on = 1'b0;
      rst_n  = 1'b0;
      pend.delete();
      #1;
      check_reset_outs("reset_mid_drain");
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (mem_wr !== 1'b0) wr_seen++;
         tick();
      end
      total++;
      if (wr_seen != 0) begin bad++; $display("FAIL reset_no_write: got %0d writes want 0", wr_seen); end
      mon_on = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; rdy = 1'b1; push_valid = 1'b0; mem_gnt = 1'b0;
      push_addr = '0; push_data = '0; push_size = '0;
      qry_addr = 32'h200; qry_size = 2'd2;
      test_reset();
      test_single_sw();
      test_fill();
      test_push_on_pop();
      test_hazard();
      test_rdy_stall();
      test_random();
      test_reset_mid_drain();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
